gf256_pow_seq: RTL and testbench

GF256_POW_SEQ -- requirements
Module: gf256_pow_seq

---
 rtl/gf256_pkg.sv | 30 +++
 rtl/gf256_power_lut.sv | 32 +++
 rtl/gf256_pow_seq.sv | 115 +++++++++++
 tb/tb_gf256_pow_seq.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/gf256_pkg.sv
// Shared definitions for the GF(2^8) power-sequence generator.
//   GF_ORDER : multiplicative group order (exponents live in 0..254)
//   GF_POLY  : field reduction polynomial x^8+x^4+x^3+x^2+1
//   gf_state_t : sequencer FSM state encoding
//   reduce_exp / mod_add : exponent arithmetic modulo GF_ORDER
package gf256_pkg;

   localparam logic [8:0] GF_ORDER = 9'd255;
   localparam logic [8:0] GF_POLY  = 9'h11D;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } gf_state_t;

   // alpha^255 == alpha^0, so exponent 255 folds onto 0
   function automatic logic [7:0] reduce_exp(input logic [7:0] e);
      return (e == 8'hFF) ? 8'h00 : e;
   endfunction

   // Both operands are already in 0..254, so one conditional subtract suffices
   function automatic logic [7:0] mod_add(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum >= GF_ORDER) sum = sum - GF_ORDER;
      return sum[7:0];
   endfunction

endpackage

// File: rtl/gf256_power_lut.sv
// Constant table of alpha^e in GF(2^8) with polynomial GF_POLY.
//   addr : exponent e (0..254 meaningful; 255 maps to alpha^255 = 1)
//   data : alpha^addr
// The table is elaborated from a constant function, so it reduces to a ROM.
module gf256_power_lut
   import gf256_pkg::*;
(
   input  logic [7:0] addr,
   output logic [7:0] data
);

   function automatic logic [7:0] alpha_pow(input logic [7:0] e);
      logic [8:0] v;
      v = 9'd1;
      for (int i = 0; i < 255; i++) begin
         if (i < int'(e)) begin
            v = v << 1;
            if (v[8]) v = v ^ GF_POLY;
         end
      end
      return v[7:0];
   endfunction

   logic [7:0] tbl [256];

   for (genvar g = 0; g < 256; g++) begin : g_tbl
      assign tbl[g] = alpha_pow(8'(g));
   end

   assign data = tbl[addr];

endmodule

// File: rtl/gf256_pow_seq.sv
// Streams the sequence alpha^(s), alpha^(s+d), alpha^(s+2d), ... (exponents
// mod 255) over a valid/ready interface.
//   clk, rst_n          : clock, async active-low reset
//   start               : begin a sequence (taken only in IDLE)
//   exp_start, exp_step : first exponent and increment (255 folds to 0)
//   count               : number of terms (0 = empty sequence)
//   out_valid/out_ready : output handshake
//   out_data            : alpha^out_exp
//   out_exp             : current exponent, 0..254
//   out_last            : marks the final term
//   busy                : sequence in progress (RUN or DONE)
//   done                : one-cycle completion pulse
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; operands captured on start
// RUN   | presenting terms, advancing on each out_valid & out_ready
// DONE  | completion cycle, done pulses; returns to IDLE
module gf256_pow_seq
   import gf256_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [7:0]       exp_start,
   input  logic [7:0]       exp_step,
   input  logic [CNT_W-1:0] count,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic [7:0]       out_exp,
   output logic             out_last,
   output logic             busy,
   output logic             done
);

   gf_state_t        state;
   logic [7:0]       step_r;
   logic [CNT_W-1:0] rem;      // terms left, including the one presented
   logic [CNT_W-1:0] rem_dec;
   logic [7:0]       exp_nxt;
   logic [7:0]       lut_data;

   // One table serves both the first term and every advance
   assign exp_nxt = (state == ST_IDLE) ? reduce_exp(exp_start)
                                       : mod_add(out_exp, step_r);
   assign rem_dec = rem - 1'b1;
   assign busy    = (state != ST_IDLE);

   gf256_power_lut u_lut (
      .addr (exp_nxt),
      .data (lut_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         step_r    <= '0;
         rem       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_exp   <= '0;
         out_last  <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  if (count != '0) begin
                     state     <= ST_RUN;
                     step_r    <= reduce_exp(exp_step);
                     rem       <= count;
                     out_valid <= 1'b1;
                     out_exp   <= exp_nxt;
                     out_data  <= lut_data;
                     out_last  <= (count == CNT_W'(1));
                  end else begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (out_ready) begin
                  if (out_last) begin
                     state     <= ST_DONE;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     rem      <= rem_dec;
                     out_exp  <= exp_nxt;
                     out_data <= lut_data;
                     out_last <= (rem_dec == CNT_W'(1));
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               done  <= 1'b0;
            end
            default: begin
               state     <= ST_IDLE;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gf256_pow_seq.sv
module tb_gf256_pow_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] exp_start;
   logic [7:0] exp_step;
   logic [7:0] count;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [7:0] out_exp;
   logic       out_last;
   logic       busy;
   logic       done;

   int total = 0;
   int bad   = 0;

   gf256_pow_seq #(.CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .exp_start (exp_start),
      .exp_step  (exp_step),
      .count     (count),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_exp   (out_exp),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // valid, data, exp, last checked together for a presented term
   task automatic term(input string tag, input logic [7:0] d, input logic [7:0] e, input logic l);
      chk({tag, ".valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".data"},  32'(out_data),  32'(d));
      chk({tag, ".exp"},   32'(out_exp),   32'(e));
      chk({tag, ".last"},  32'(out_last),  32'(l));
   endtask

   task automatic all_zero(input string tag);
      chk({tag, ".valid"}, 32'(out_valid), 32'd0);
      chk({tag, ".data"},  32'(out_data),  32'd0);
      chk({tag, ".exp"},   32'(out_exp),   32'd0);
      chk({tag, ".last"},  32'(out_last),  32'd0);
      chk({tag, ".busy"},  32'(busy),      32'd0);
      chk({tag, ".done"},  32'(done),      32'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; exp_start = 8'd0; exp_step = 8'd0;
      count = 8'd0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      all_zero("reset");

      // exp 0, step 1, count 3; start together with reset release
      rst_n = 1'b1; start = 1'b1; exp_start = 8'd0; exp_step = 8'd1;
      count = 8'd3; out_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      term("t1a", 8'h01, 8'd0, 1'b0);
      chk("t1a.busy", 32'(busy), 32'd1);
      @(negedge clk); term("t1b", 8'h02, 8'd1, 1'b0);
      @(negedge clk); term("t1c", 8'h04, 8'd2, 1'b1);
      chk("t1c.done", 32'(done), 32'd0);
      @(negedge clk);
      chk("t1.done", 32'(done), 32'd1);
      chk("t1.valid_off", 32'(out_valid), 32'd0);
      chk("t1.busy_done", 32'(busy), 32'd1);
      @(negedge clk);
      chk("t1.done_clr", 32'(done), 32'd0);
      chk("t1.idle_busy", 32'(busy), 32'd0);

      // wrap across 255: 254 -> 1 -> 3
      start = 1'b1; exp_start = 8'd254; exp_step = 8'd2; count = 8'd3;
      @(negedge clk); start = 1'b0;
      term("t2a", 8'h8E, 8'd254, 1'b0);
      @(negedge clk); term("t2b", 8'h02, 8'd1, 1'b0);
      @(negedge clk); term("t2c", 8'h08, 8'd3, 1'b1);
      @(negedge clk); chk("t2.done", 32'(done), 32'd1);
      @(negedge clk);

      // backpressure: hold term while out_ready low; start in RUN ignored
      start = 1'b1; exp_start = 8'd8; exp_step = 8'd1; count = 8'd2; out_ready = 1'b0;
      @(negedge clk); exp_start = 8'd0; count = 8'd5;
      term("t3h1", 8'h1D, 8'd8, 1'b0);
      @(negedge clk); term("t3h2", 8'h1D, 8'd8, 1'b0);
      @(negedge clk); term("t3h3", 8'h1D, 8'd8, 1'b0);
      start = 1'b0; out_ready = 1'b1;
      @(negedge clk); term("t3b", 8'h3A, 8'd9, 1'b1);
      @(negedge clk);
      chk("t3.done", 32'(done), 32'd1);
      chk("t3.valid_off", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("t3.idle", 32'(busy), 32'd0);

      // empty sequence
      start = 1'b1; exp_start = 8'd7; exp_step = 8'd1; count = 8'd0;
      @(negedge clk); start = 1'b0;
      chk("t4.done", 32'(done), 32'd1);
      chk("t4.busy", 32'(busy), 32'd1);
      chk("t4.valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("t4.done_clr", 32'(done), 32'd0);
      chk("t4.busy_clr", 32'(busy), 32'd0);
      chk("t4.valid2", 32'(out_valid), 32'd0);

      // 255 folds to 0 for both start and step
      start = 1'b1; exp_start = 8'd255; exp_step = 8'd255; count = 8'd2;
      @(negedge clk); start = 1'b0;
      term("t5a", 8'h01, 8'd0, 1'b0);
      @(negedge clk); term("t5b", 8'h01, 8'd0, 1'b1);
      @(negedge clk); chk("t5.done", 32'(done), 32'd1);
      @(negedge clk);

      // reset mid-sequence, then a fresh sequence
      start = 1'b1; exp_start = 8'd5; exp_step = 8'd3; count = 8'd10;
      @(negedge clk); start = 1'b0;
      term("t6a", 8'h20, 8'd5, 1'b0);
      @(negedge clk); term("t6b", 8'h1D, 8'd8, 1'b0);
      #1 rst_n = 1'b0;
      #1 all_zero("t6.rst");
      @(negedge clk); all_zero("t6.rst_hold");
      rst_n = 1'b1; start = 1'b1; exp_start = 8'd9; exp_step = 8'd1; count = 8'd1;
      @(negedge clk); start = 1'b0;
      term("t6c", 8'h3A, 8'd9, 1'b1);
      @(negedge clk); chk("t6.done", 32'(done), 32'd1);
      @(negedge clk); chk("t6.idle", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
